// File: rtl/fnd_receiver_pkg.sv
// Shared definitions for the FND bus receiver: segment patterns, decode codes,
// FSM state type and small helper functions.
package fnd_receiver_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } rx_state_e;

    function automatic logic [3:0] seg_to_code(input logic [6:0] seg);
        case (seg)
            SEG_0:     return 4'h0;
            SEG_1:     return 4'h1;
            SEG_2:     return 4'h2;
            SEG_3:     return 4'h3;
            SEG_4:     return 4'h4;
            SEG_5:     return 4'h5;
            SEG_6:     return 4'h6;
            SEG_7:     return 4'h7;
            SEG_8:     return 4'h8;
            SEG_9:     return 4'h9;
            SEG_MINUS: return CODE_MINUS;
            SEG_BLANK: return CODE_BLANK;
            default:   return CODE_BAD;
        endcase
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment pattern to 4-bit digit code; the dp bit is ignored.
module fnd_seg_decode
    import fnd_receiver_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] code
);

    logic unused_dp_s;

    assign unused_dp_s = pattern[7];
    assign code        = seg_to_code(pattern[6:0]);

endmodule

// File: rtl/fnd_receiver.sv
// Receiver for the scanned 6-digit FND bus: reassembles complete display frames.
// Optional digit decoding into frame_code is enabled by FND_RECEIVER_DECODE_EN.
module fnd_receiver
    import fnd_receiver_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clock_50m,
    input  logic        rst,
    input  logic [5:0]  fnd_s,
    input  logic [7:0]  fnd_d,
    output logic [47:0] frame_seg,
    output logic [23:0] frame_code,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]       MASK_FULL = 6'b111111;

    logic [13:0]      sync_r [SYNC_STAGES];
    logic [13:0]      bus_s;
    logic [13:0]      bus_prev_r;
    logic [5:0]       sel_s;
    logic [7:0]       seg_s;
    logic [CNT_W-1:0] stable_cnt_r;
    logic [CNT_W-1:0] stable_cnt_next_s;
    logic             captured_r;
    logic             changed_s;
    logic             capture_s;
    logic [5:0]       cap_onehot_s;
    logic [47:0]      slot_r;
    logic [47:0]      slot_next_s;
    logic [5:0]       mask_r;
    logic [5:0]       mask_next_s;
    logic [5:0]       mask_cap_s;
    logic [TMO_W-1:0] tmo_r;
    logic [TMO_W-1:0] tmo_next_s;
    rx_state_e        state_r;
    rx_state_e        state_next_s;
    logic             load_s;
    logic             err_s;
    logic [47:0]      frame_seg_r;
    logic             frame_valid_r;
    logic             frame_err_r;
    logic             busy_r;

    assign bus_s = sync_r[SYNC_STAGES-1];
    assign sel_s = bus_s[13:8];
    assign seg_s = bus_s[7:0];

    // Input synchronizer chain for the whole {select, segment} bus
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= 14'h0000;
        end else begin
            sync_r[0] <= {fnd_s, fnd_d};
            for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
        end
    end

    // Dwell stability tracking and the capture decision for the selected slot
    always_comb begin
        changed_s = (bus_s != bus_prev_r);
        if (changed_s) begin
            stable_cnt_next_s = '0;
        end else if (stable_cnt_r == CNT_MAX) begin
            stable_cnt_next_s = CNT_MAX;
        end else begin
            stable_cnt_next_s = stable_cnt_r + CNT_W'(1);
        end
        capture_s    = is_one_hot(~sel_s) && !captured_r && (stable_cnt_next_s == CNT_MAX);
        cap_onehot_s = capture_s ? ~sel_s : 6'b000000;
        slot_next_s  = slot_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_onehot_s[i]) begin
                slot_next_s[8*i +: 8] = seg_s;
            end else begin
                slot_next_s[8*i +: 8] = slot_r[8*i +: 8];
            end
        end
    end

    // Stability counter, per-dwell captured flag and digit slots
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            bus_prev_r   <= 14'h0000;
            stable_cnt_r <= '0;
            captured_r   <= 1'b0;
            slot_r       <= 48'h0;
        end else begin
            bus_prev_r   <= bus_s;
            stable_cnt_r <= stable_cnt_next_s;
            slot_r       <= slot_next_s;
            if (changed_s) begin
                captured_r <= 1'b0;
            end else if (capture_s) begin
                captured_r <= 1'b1;
            end
        end
    end

    // Frame FSM state, capture mask and timeout counter registers
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            mask_r  <= 6'b000000;
            tmo_r   <= '0;
        end else begin
            state_r <= state_next_s;
            mask_r  <= mask_next_s;
            tmo_r   <= tmo_next_s;
        end
    end

    // Frame FSM next state: completion beats a coincident timeout
    always_comb begin
        state_next_s = state_r;
        mask_next_s  = mask_r;
        tmo_next_s   = tmo_r;
        load_s       = 1'b0;
        err_s        = 1'b0;
        mask_cap_s   = mask_r | cap_onehot_s;
        case (state_r)
            ST_IDLE: begin
                tmo_next_s = '0;
                if (capture_s) begin
                    state_next_s = ST_COLLECT;
                    mask_next_s  = cap_onehot_s;
                end else begin
                    mask_next_s  = 6'b000000;
                end
            end
            ST_COLLECT: begin
                if (mask_cap_s == MASK_FULL) begin
                    state_next_s = ST_DONE;
                    mask_next_s  = mask_cap_s;
                    load_s       = 1'b1;
                end else if (tmo_r == TMO_LAST) begin
                    state_next_s = ST_IDLE;
                    mask_next_s  = 6'b000000;
                    err_s        = 1'b1;
                end else begin
                    mask_next_s  = mask_cap_s;
                    tmo_next_s   = tmo_r + TMO_W'(1);
                end
            end
            ST_DONE: begin
                mask_next_s  = cap_onehot_s;
                tmo_next_s   = '0;
                state_next_s = capture_s ? ST_COLLECT : ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                mask_next_s  = 6'b000000;
                tmo_next_s   = '0;
            end
        endcase
    end

    // Registered frame outputs, updated on the edge that enters DONE
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            frame_seg_r   <= 48'h0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_valid_r <= load_s;
            frame_err_r   <= err_s;
            busy_r        <= (state_next_s == ST_COLLECT);
            if (load_s) begin
                frame_seg_r <= slot_next_s;
            end
        end
    end

    assign frame_seg   = frame_seg_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

`ifdef FND_RECEIVER_DECODE_EN
    logic [23:0] code_next_s;
    logic [23:0] frame_code_r;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        fnd_seg_decode u_dec (
            .pattern (slot_next_s[8*g +: 8]),
            .code    (code_next_s[4*g +: 4])
        );
    end

    // Decoded frame register, loaded together with frame_seg
    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            frame_code_r <= 24'hFFFFFF;
        end else if (load_s) begin
            frame_code_r <= code_next_s;
        end
    end

    assign frame_code = frame_code_r;
`else
    assign frame_code = {NUM_DIGITS{CODE_BAD}};
`endif

endmodule

// File: tb/tb_fnd_receiver.sv
// Randomized self-checking bench for fnd_receiver against a frame-level reference model.
module tb_fnd_receiver;

    localparam int STABLE = 8;
    localparam int TMO    = 800;

    localparam logic [7:0] PATS  [12] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                                          8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h40, 8'h00};
    localparam logic [3:0] CODES [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                          4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  fnd_s;
    logic [7:0]  fnd_d;
    logic [47:0] frame_seg;
    logic [23:0] frame_code;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;
    logic [7:0]  dec_pat;
    logic [3:0]  dec_code;

    int          n_vec = 0;
    int          n_err = 0;
    int          err_pulses = 0;
    logic [47:0] exp_q [$];
    logic [47:0] mon_exp;
    logic [7:0]  mdl_slot [6];
    logic [5:0]  mdl_mask;

    fnd_receiver #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock_50m   (clk),
        .rst         (rst),
        .fnd_s       (fnd_s),
        .fnd_d       (fnd_d),
        .frame_seg   (frame_seg),
        .frame_code  (frame_code),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    fnd_seg_decode u_dec (
        .pattern (dec_pat),
        .code    (dec_code)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [7:0] p);
        logic [3:0] c;
        c = 4'hF;
        for (int j = 0; j < 12; j++) begin
            if ((p & 8'h7F) == PATS[j]) c = CODES[j];
        end
        return c;
    endfunction

    function automatic logic [23:0] exp_code(input logic [47:0] seg);
        logic [23:0] r;
        r = 24'hFFFFFF;
`ifdef FND_RECEIVER_DECODE_EN
        for (int i = 0; i < 6; i++) r[4*i +: 4] = ref_decode(seg[8*i +: 8]);
`endif
        return r;
    endfunction

    function automatic logic [5:0] sel(input int dig);
        logic [5:0] one;
        one = 6'b000001 << dig;
        return ~one;
    endfunction

    // Frame model: a held value with exactly one select low captures once it lasts STABLE+1 cycles.
    task automatic model_apply(input logic [5:0] s, input logic [7:0] d, input int n);
        int zeros;
        int idx;
        logic [47:0] f;
        zeros = 0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            if (!s[i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros == 1 && n >= STABLE + 1) begin
            mdl_slot[idx] = d;
            mdl_mask[idx] = 1'b1;
            if (&mdl_mask) begin
                for (int i = 0; i < 6; i++) f[8*i +: 8] = mdl_slot[i];
                exp_q.push_back(f);
                mdl_mask = 6'b000000;
            end
        end
    endtask

    task automatic send(input logic [5:0] s, input logic [7:0] d, input int n);
        fnd_s = s;
        fnd_d = d;
        model_apply(s, d, n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap();
        case ($urandom_range(2, 0))
            0:       send(6'b111111, 8'h00, 3);
            1:       send(6'b111100, 8'($urandom_range(255, 0)), 12);
            default: send(6'b011011, 8'($urandom_range(255, 0)), 12);
        endcase
    endtask

    task automatic rand_frame();
        int order [6];
        int j;
        int t;
        int dig;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) order[i] = i;
        for (int i = 5; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int k = 0; k < 6; k++) begin
            dig = order[k];
            d = 8'($urandom_range(254, 0));
            if (k < 5 && $urandom_range(3, 0) == 0) begin
                send(sel(dig), d, $urandom_range(14, 10));
                send(sel(dig), 8'hFF, STABLE - 1);
                send(sel(dig), d, $urandom_range(14, 10));
            end else begin
                send(sel(dig), d, $urandom_range(24, 12));
            end
            gap();
            check_eq("busy", 48'(busy), 48'(mdl_mask != 6'd0));
            if (k < 5 && $urandom_range(3, 0) == 0) begin
                dig = order[$urandom_range(k, 0)];
                send(sel(dig), 8'($urandom_range(254, 0)), 14);
                gap();
            end
        end
    endtask

    // Frame monitor: every frame_valid cycle must match the next modelled frame
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (frame_err === 1'b1) err_pulses++;
            if (frame_valid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", 48'(frame_valid), 48'h0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_eq("frame_seg", frame_seg, mon_exp);
                    check_eq("frame_code", 48'(frame_code), 48'(exp_code(mon_exp)));
                end
            end
        end
    end

    initial begin
        logic [47:0] saved_seg;
        int          e0;

        rst      = 1'b0;
        fnd_s    = 6'b111111;
        fnd_d    = 8'h00;
        dec_pat  = 8'h00;
        mdl_mask = 6'b000000;
        for (int i = 0; i < 6; i++) mdl_slot[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_seg", frame_seg, 48'h0);
        check_eq("rst_code", 48'(frame_code), 48'hFFFFFF);
        check_eq("rst_valid", 48'(frame_valid), 48'h0);
        check_eq("rst_err", 48'(frame_err), 48'h0);
        check_eq("rst_busy", 48'(busy), 48'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int p = 0; p < 256; p++) begin
            dec_pat = 8'(p);
            #1;
            check_eq("seg_decode", 48'(dec_code), 48'(ref_decode(8'(p))));
        end

        // normal scan, digits 5..0
        send(sel(5), 8'h06, 20);
        check_eq("busy_first", 48'(busy), 48'h1);
        send(sel(4), 8'h5B, 20);
        send(sel(3), 8'h4F, 20);
        send(sel(2), 8'h66, 20);
        send(sel(1), 8'h6D, 20);
        send(sel(0), 8'h7D, 20);
        send(6'b111111, 8'h00, 10);
        check_eq("normal_seg", frame_seg, 48'h065B4F666D7D);
        check_eq("normal_code", 48'(frame_code), 48'(exp_code(48'h065B4F666D7D)));
        check_eq("normal_pending", 48'(exp_q.size()), 48'h0);
        check_eq("normal_busy", 48'(busy), 48'h0);

        for (int f = 0; f < 20; f++) rand_frame();
        send(6'b111111, 8'h00, 20);
        check_eq("rand_pending", 48'(exp_q.size()), 48'h0);
        check_eq("rand_err", 48'(err_pulses), 48'h0);

        // negative number display
        send(sel(5), 8'h00, 20);
        send(sel(4), 8'h80, 20);
        send(sel(3), 8'h40, 20);
        send(sel(2), 8'h06, 20);
        send(sel(1), 8'h5B, 20);
        send(sel(0), 8'hCF, 20);
        send(6'b111111, 8'h00, 10);
        check_eq("neg_seg", frame_seg, 48'h008040065BCF);
`ifdef FND_RECEIVER_DECODE_EN
        check_eq("neg_code", 48'(frame_code), 48'hBBA123);
`else
        check_eq("neg_code", 48'(frame_code), 48'hFFFFFF);
`endif

        // timeout: digit 5 never shows up
        saved_seg = frame_seg;
        e0 = err_pulses;
        for (int r = 0; r < 8; r++) begin
            for (int dig = 0; dig < 5; dig++) send(sel(dig), 8'($urandom_range(254, 0)), 20);
            if (r == 0) check_eq("tmo_busy", 48'(busy), 48'h1);
        end
        send(6'b111111, 8'h00, 80);
        mdl_mask = 6'b000000;
        check_eq("tmo_err_pulses", 48'(err_pulses - e0), 48'h1);
        check_eq("tmo_busy_drop", 48'(busy), 48'h0);
        check_eq("tmo_seg_kept", frame_seg, saved_seg);
        check_eq("tmo_pending", 48'(exp_q.size()), 48'h0);

        // reset in the middle of a frame
        send(sel(0), 8'h11, 20);
        send(sel(1), 8'h22, 20);
        send(sel(2), 8'h33, 20);
        fnd_s = 6'b111111;
        fnd_d = 8'h00;
        rst = 1'b0;
        #2;
        check_eq("mid_rst_seg", frame_seg, 48'h0);
        check_eq("mid_rst_code", 48'(frame_code), 48'hFFFFFF);
        check_eq("mid_rst_valid", 48'(frame_valid), 48'h0);
        check_eq("mid_rst_err", 48'(frame_err), 48'h0);
        check_eq("mid_rst_busy", 48'(busy), 48'h0);
        mdl_mask = 6'b000000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst_pending", 48'(exp_q.size()), 48'h0);
        rand_frame();
        send(6'b111111, 8'h00, 20);
        check_eq("post_rst_frame", 48'(exp_q.size()), 48'h0);
        check_eq("post_rst_err", 48'(err_pulses - e0), 48'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
